// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache; misses refill over a shared byte-wide RAM port.
// Define ICACHE_STATS_EN to add hit_cnt_o / miss_cnt_o lookup counters.
module icache_fetch #(
    parameter int unsigned INDEX_BITS = 7,
    parameter int unsigned ADDR_BITS  = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    input  logic [ADDR_BITS-1:0] req_addr_i,
    input  logic                 abort_i,
    input  logic                 flush_i,
    output logic [31:0]          inst_o,
    output logic                 inst_valid_o,
    output logic                 busy_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_rd_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    input  logic [7:0]           mem_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int unsigned LINES  = 2 ** INDEX_BITS;
    localparam int unsigned LINE_W = ADDR_BITS - 2;
    localparam int unsigned TAG_W  = ADDR_BITS - 2 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t                 state_q, state_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [2:0]             issue_cnt_q, issue_cnt_d;
    logic [1:0]             rcv_cnt_q, rcv_cnt_d;
    logic                   pend_q;
    logic [23:0]            buf_q, buf_d;
    logic [31:0]            inst_q, inst_d;
    logic                   inst_valid_q, inst_valid_d;
    logic                   busy_q, busy_d;
    logic [ADDR_BITS-1:0]   addr_q;

    logic [31:0]            data_mem [LINES];
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [LINES-1:0]       valid_q;

    logic [INDEX_BITS-1:0]  lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   lk_hit;
    logic                   accept;
    logic                   issue;
    logic                   fill;
    logic [31:0]            fill_word;
    logic [INDEX_BITS-1:0]  fill_idx;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^req_addr_i[1:0];

    // Combinational lookup; a same-cycle flush forces a miss.
    assign lk_idx    = req_addr_i[INDEX_BITS+1:2];
    assign lk_tag    = req_addr_i[ADDR_BITS-1:INDEX_BITS+2];
    assign lk_hit    = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag) && !flush_i;
    assign accept    = (state_q == IDLE) && req_valid_i && !abort_i;
    assign fill_word = {mem_data_i, buf_q};
    assign fill_idx  = line_q[INDEX_BITS-1:0];

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        issue_cnt_d  = issue_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        buf_d        = buf_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        busy_d       = busy_q;
        issue        = 1'b0;
        fill         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lk_hit) begin
                        inst_d       = data_mem[lk_idx];
                        inst_valid_d = 1'b1;
                    end else begin
                        line_d      = req_addr_i[ADDR_BITS-1:2];
                        issue_cnt_d = 3'd0;
                        rcv_cnt_d   = 2'd0;
                        busy_d      = 1'b1;
                        state_d     = REFILL;
                    end
                end
            end
            REFILL: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    issue = mem_gnt_i && (issue_cnt_q < 3'd4);
                    if (issue) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                    end
                    // Byte returned for the read issued last cycle lands in lane rcv_cnt.
                    if (pend_q) begin
                        rcv_cnt_d = rcv_cnt_q + 2'd1;
                        case (rcv_cnt_q)
                            2'd0:    buf_d[7:0]   = mem_data_i;
                            2'd1:    buf_d[15:8]  = mem_data_i;
                            2'd2:    buf_d[23:16] = mem_data_i;
                            default: begin
                                fill         = 1'b1;
                                inst_d       = fill_word;
                                inst_valid_d = 1'b1;
                                busy_d       = 1'b0;
                                state_d      = RESP;
                            end
                        endcase
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd_o     = issue;
    assign mem_addr_o   = issue ? {line_q, issue_cnt_q[1:0]} : addr_q;
    assign inst_o       = inst_q;
    // An abort arriving in the response cycle still cancels the pulse.
    assign inst_valid_o = inst_valid_q && !((state_q == RESP) && abort_i);
    assign busy_o       = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            line_q       <= '0;
            issue_cnt_q  <= 3'd0;
            rcv_cnt_q    <= 2'd0;
            pend_q       <= 1'b0;
            buf_q        <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            issue_cnt_q  <= issue_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            pend_q       <= issue;
            buf_q        <= buf_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
            addr_q       <= mem_addr_o;
        end
    end

    // The completing refill wins over a same-edge flush for its own line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end
            if (fill) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[fill_idx] <= fill_word;
            tag_mem[fill_idx]  <= line_q[LINE_W-1:INDEX_BITS];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q  <= 32'd0;
            miss_q <= 32'd0;
        end else if (flush_i) begin
            hit_q  <= 32'd0;
            miss_q <= 32'd0;
        end else if (accept) begin
            if (lk_hit) begin
                hit_q <= hit_q + 32'd1;
            end else begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_q;
    assign miss_cnt_o = miss_q;
`endif

endmodule
